// File: rtl/disp_pkg.sv
// Shared types and constants for the product display scanner.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    // An 8-bit magnitude needs one double-dabble step per bit
    localparam int unsigned DD_STEPS = 8;

    // Double-dabble correction: add 3 to every BCD nibble that is >= 5
    function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// Generic BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_digit_decoder
    import disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins over the digit value; non-decimal codes show an error glyph
    always_comb begin
        seg_o = SEG_ERR;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (bcd_i)
                4'd0:    seg_o = 7'b1000000;
                4'd1:    seg_o = 7'b1111001;
                4'd2:    seg_o = 7'b0100100;
                4'd3:    seg_o = 7'b0110000;
                4'd4:    seg_o = 7'b0011001;
                4'd5:    seg_o = 7'b0010010;
                4'd6:    seg_o = 7'b0000010;
                4'd7:    seg_o = 7'b1111000;
                4'd8:    seg_o = 7'b0000000;
                4'd9:    seg_o = 7'b0011000;
                default: seg_o = SEG_ERR;
            endcase
        end
    end

endmodule

// File: rtl/product_display_scanner.sv
// Signed product -> sign/H/T/U via sequential double-dabble, then a
// time-multiplexed four-digit 7-segment scan with registered pin outputs.
module product_display_scanner
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] product_i,
    input  logic       valid_i,
    output logic       busy_o,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       dp_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    conv_state_t      state_q, state_d;
    logic             sign_q, sign_d;
    // {BCD[11:0], binary[7:0]} shifted left as one register
    logic [19:0]      dd_q, dd_d;
    logic [2:0]       step_q, step_d;

    // Display registers: only rewritten when a conversion completes
    logic [3:0]       units_q, units_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       hund_q, hund_d;
    logic             tens_blank_q, tens_blank_d;
    logic             hund_blank_q, hund_blank_d;
    logic             neg_q, neg_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic [7:0]       mag;
    logic [19:0]      dd_adj;
    logic [3:0]       cur_bcd;
    logic             cur_blank;
    logic [6:0]       dec_seg;

    // |product| fits 8 unsigned bits: 8'h80 negates to itself, which reads as 128
    assign mag    = product_i[7] ? (~product_i + 8'd1) : product_i;
    assign dd_adj = {dd_adjust(dd_q[19:8]), dd_q[7:0]};

    // Conversion FSM and display register load
    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        dd_d         = dd_q;
        step_d       = step_q;
        units_d      = units_q;
        tens_d       = tens_q;
        hund_d       = hund_q;
        tens_blank_d = tens_blank_q;
        hund_blank_d = hund_blank_q;
        neg_d        = neg_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sign_d  = product_i[7];
                    dd_d    = {12'd0, mag};
                    step_d  = 3'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                dd_d   = {dd_adj[18:0], 1'b0};
                step_d = step_q + 3'd1;
                if (step_q == 3'(DD_STEPS - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                hund_d       = dd_q[19:16];
                tens_d       = dd_q[15:12];
                units_d      = dd_q[11:8];
                hund_blank_d = (dd_q[19:16] == 4'd0);
                tens_blank_d = (dd_q[19:12] == 8'd0);
                // A zero magnitude never shows a minus
                neg_d        = sign_q && (dd_q[19:8] != 12'd0);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh counter, digit select and the pattern for the selected digit
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        cur_bcd   = units_q;
        cur_blank = 1'b0;
        case (idx_q)
            2'd1: begin cur_bcd = tens_q; cur_blank = tens_blank_q; end
            2'd2: begin cur_bcd = hund_q; cur_blank = hund_blank_q; end
            2'd3: begin cur_bcd = 4'd0;   cur_blank = 1'b1;         end
            default: ;
        endcase
        seg_d = (idx_q == 2'd3) ? (neg_q ? SEG_MINUS : SEG_BLANK) : dec_seg;
        an_d  = ~(4'b0001 << idx_q);
    end

    seg7_digit_decoder u_dec (
        .bcd_i   (cur_bcd),
        .blank_i (cur_blank),
        .seg_o   (dec_seg)
    );

    // State registers; reset aborts any conversion and shows a lone "0"
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sign_q       <= 1'b0;
            dd_q         <= '0;
            step_q       <= '0;
            units_q      <= 4'd0;
            tens_q       <= 4'd0;
            hund_q       <= 4'd0;
            tens_blank_q <= 1'b1;
            hund_blank_q <= 1'b1;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            seg_q        <= 7'b1000000;
            an_q         <= 4'b1110;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            dd_q         <= dd_d;
            step_q       <= step_d;
            units_q      <= units_d;
            tens_q       <= tens_d;
            hund_q       <= hund_d;
            tens_blank_q <= tens_blank_d;
            hund_blank_q <= hund_blank_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign seg_o  = seg_q;
    assign an_o   = an_q;
    assign dp_o   = 1'b1;

endmodule

// File: tb/tb_product_display_scanner.sv
// Randomized self-checking bench with a decimal-arithmetic reference model.
module tb_product_display_scanner;

    localparam int DIV = 4;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] MIN = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] product_i = 8'd0;
    logic       valid_i = 1'b0;
    logic       busy_o;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       dp_o;

    int checks = 0;
    int failures = 0;

    product_display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .product_i (product_i),
        .valid_i   (valid_i),
        .busy_o    (busy_o),
        .seg_o     (seg_o),
        .an_o      (an_o),
        .dp_o      (dp_o)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0011000};

    // Reference model: what each digit must show, derived from decimal arithmetic
    int         m_busy_left = 0;
    int         m_cnt = 0;
    int         m_idx = 0;
    bit         m_on = 0;
    logic [7:0] m_val = 8'd0;
    logic [6:0] m_disp [4];
    logic [6:0] e_seg = 7'b1000000;
    logic [3:0] e_an = 4'b1110;
    logic [6:0] cap [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_load(input logic [7:0] p);
        int mag, h, t, u;
        mag = p[7] ? 256 - int'(p) : int'(p);
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        m_disp[0] = seg_tab[u];
        m_disp[1] = (h == 0 && t == 0) ? BLK : seg_tab[t];
        m_disp[2] = (h == 0) ? BLK : seg_tab[h];
        m_disp[3] = (p[7] && mag != 0) ? MIN : BLK;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy_left = 0;
            m_cnt = 0;
            m_idx = 0;
            m_disp[0] = seg_tab[0];
            m_disp[1] = BLK;
            m_disp[2] = BLK;
            m_disp[3] = BLK;
            e_seg = 7'b1000000;
            e_an = 4'b1110;
            m_on = 1;
        end else begin
            e_an = ~(4'b0001 << m_idx);
            e_seg = m_disp[m_idx];
            if (m_busy_left == 0) begin
                if (valid_i) begin
                    m_val = product_i;
                    m_busy_left = 9;
                end
            end else begin
                m_busy_left--;
                if (m_busy_left == 0) model_load(m_val);
            end
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end
        end
    end

    // Every-cycle comparison against the model, plus per-anode capture
    always @(negedge clk) begin
        if (m_on) begin
            chk("busy", 32'(busy_o), 32'(m_busy_left != 0));
            chk("an", 32'(an_o), 32'(e_an));
            chk("seg", 32'(seg_o), 32'(e_seg));
            chk("dp", 32'(dp_o), 32'd1);
        end
        case (an_o)
            4'b1110: cap[0] = seg_o;
            4'b1101: cap[1] = seg_o;
            4'b1011: cap[2] = seg_o;
            4'b0111: cap[3] = seg_o;
            default: ;
        endcase
    end

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        product_i = v;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic busy_len(input string name);
        int n;
        n = 0;
        while (busy_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'd9);
    endtask

    task automatic digits(input string name, input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0);
        repeat (20) @(negedge clk);
        chk({name, "_sign"}, 32'(cap[3]), 32'(s3));
        chk({name, "_hund"}, 32'(cap[2]), 32'(s2));
        chk({name, "_tens"}, 32'(cap[1]), 32'(s1));
        chk({name, "_units"}, 32'(cap[0]), 32'(s0));
    endtask

    initial begin
        // Reset held three cycles
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an_o), 32'b1110);
        chk("rst_seg", 32'(seg_o), 32'b1000000);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_dp", 32'(dp_o), 32'd1);
        rst_n = 1'b1;
        digits("zero", BLK, BLK, BLK, 7'b1000000);

        send(8'd42);
        busy_len("busy_42");
        digits("p42", BLK, BLK, 7'b0011001, 7'b0100100);

        send(8'hD6);
        busy_len("busy_m42");
        digits("m42", MIN, BLK, 7'b0011001, 7'b0100100);

        send(8'h80);
        busy_len("busy_m128");
        digits("m128", MIN, 7'b1111001, 7'b0100100, 7'b0000000);

        send(8'd64);
        busy_len("busy_64");
        digits("p64", BLK, BLK, 7'b0000010, 7'b0011001);

        // Second strobe three cycles into a conversion is dropped
        send(8'd7);
        @(negedge clk);
        product_i = 8'd99;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        digits("ignored", BLK, BLK, BLK, 7'b1111000);

        // Reset during CONVERT step 4 discards the conversion and the old display
        send(8'd42);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_an", 32'(an_o), 32'b1110);
        chk("mid_rst_seg", 32'(seg_o), 32'b1000000);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        digits("mid_rst", BLK, BLK, BLK, 7'b1000000);

        // Random traffic: pulses, held strobes, occasional reset
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            product_i = 8'($urandom);
            valid_i = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
        end
        valid_i = 1'b0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
